display_scan_driver: RTL and testbench
======================================

# display_scan_driver

Multiplexed 7-segment scan driver that sits directly upstream of the 595 shift-register stage. It cycles through the display digits at a fixed rate, encodes each digit's 4-bit value into a segment pattern, and packs segments plus a one-hot digit select into a 16-bit word. It then issues a one-cycle trigger to the 595 driver for each digit, and holds that word stable for the whole shift-out.

## Interface
Parameters:
- NUM_DIGITS, 4, number of scanned digits (1..8)
- SCAN_DIV, 4096, clock cycles per digit slot; must be ≥ 40 so each word outlives a full 16-bit shift-out (elaboration-time check)
- SEG_ACTIVE_LOW, 0, 1 inverts all segment bits (common-anode)
- DIG_ACTIVE_LOW, 1, 1 makes digit selects active-low

Ports:
- clk_i  in  1  clock; single clock domain
- rst_i  in  1  synchronous, active-high reset
- digits_i  in  4*NUM_DIGITS  digit values, digit k at [4k+3:4k]; digit 0 is least significant
- dp_i  in  NUM_DIGITS  decimal point per digit (1 = lit)
- lz_blank_i  in  1  leading-zero blanking enable
- blank_i  in  1  force whole display off
- data_o  out  16  word to 595 stage: [15:8] segments {dp,g,f,e,d,c,b,a}, [7:0] digit select (bit k = digit k)
- trigger_o  out  1  one-cycle pulse: start shifting data_o
- digit_idx_o  out  3  index of digit currently held in data_o

## Operation
- Divider div_cnt counts 0..SCAN_DIV-1, wrapping to 0.
- Scan index scan_idx counts 0..NUM_DIGITS-1, wrapping to 0.
- Load event: the cycle with div_cnt == SCAN_DIV-1.
  - data_o is registered from the word for scan_idx.
  - digit_idx_o <= scan_idx; scan_idx advances.
  - digits_i, dp_i, lz_blank_i and blank_i are sampled in this cycle only.
- Segment encoding (active-high, before SEG_ACTIVE_LOW inversion, bits g..a):
  - 0:0x3F, 1:0x06, 2:0x5B, 3:0x4F, 4:0x66, 5:0x6D, 6:0x7D, 7:0x07, 8:0x7F, 9:0x6F
  - 10..14: 0x00 (blank); 15: 0x40 ('-')
  - dp bit = dp_i[k].
- Leading-zero blanking: when lz_blank_i = 1, digit k is blanked (segments 0x00, dp kept) if digits k..NUM_DIGITS-1 are all 0. Digit 0 is never blanked.
- blank_i = 1: segments all off (including dp) and all digit selects inactive. The scan and triggers continue normally.
- Digit select: only bit scan_idx is active. Bits ≥ NUM_DIGITS are always inactive. Polarity follows DIG_ACTIVE_LOW.
- Polarity is applied last: SEG_ACTIVE_LOW inverts [15:8], DIG_ACTIVE_LOW inverts [7:0].
- Between load events, data_o is held constant.

## Timing
- Reset values (from the cycle after rst_i is sampled high):
  - data_o = all-off word (segments inactive, selects inactive); with defaults 0x00FF
  - trigger_o = 0, digit_idx_o = 0, div_cnt = 0, scan_idx = 0
- First load happens at the SCAN_DIV-th rising edge after rst_i is sampled low. trigger_o is high for exactly the next cycle.
- Steady state: one trigger every SCAN_DIV cycles, exactly one cycle wide, always one cycle after data_o changes.
- data_o is stable from 1 cycle before trigger_o until SCAN_DIV-1 cycles after it.
- Latency: input change → visible in data_o at the next load event. Changes between load events are ignored.
- Full frame: NUM_DIGITS*SCAN_DIV cycles.
- Reset mid-slot or mid-trigger: the reset values apply on the next edge, any pending trigger is dropped, and the scan restarts at digit 0.
- NUM_DIGITS = 1: scan_idx stays 0 and every trigger refreshes digit 0.

## Test plan
- Reset/first word (defaults, SCAN_DIV=40): digits_i=0x1234, no blanking, rst_i released.
  - data_o=0x00FF and trigger_o=0 for 39 cycles after release.
  - Edge 40: data_o=0x66FE (digit 0 = '4').
  - Cycle 41: trigger_o=1 for one cycle only.
- Full scan: digits_i=0x1234.
  - Successive loads: 0x66FE, 0x4FFD, 0x5BFB, 0x06F7, then wrap to 0x66FE.
  - digit_idx_o: 0,1,2,3,0.
  - Trigger spacing exactly 40 cycles.
- Leading zeros: digits_i=0x0070, lz_blank_i=1, dp_i=4'b1000.
  - Digit 3: 0x80F7 (blank, dp kept). Digit 2: 0x00FB. Digit 1: 0x07FD. Digit 0: 0x3FFE.
- Codes/blank: digit value 15 gives segments 0x40; value 12 gives 0x00.
  - blank_i=1 gives data_o=0x00FF at every load while trigger_o keeps pulsing.
- Input change mid-slot: change digits_i 5 cycles after a load → data_o unchanged until the next load, which reflects the new value.
- Reset during trigger cycle: rst_i high on the trigger_o=1 cycle → trigger_o=0 next cycle, data_o=0x00FF, and the next load is digit 0 after 40 cycles.

Source files
------------

// File: rtl/display_scan_driver.sv
// Multiplexed 7-segment scan driver: builds one {segments, digit-select} word per
// digit slot and hands it to the downstream 595 shifter with a one-cycle trigger.
module display_scan_driver #(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned SCAN_DIV       = 4096,
    parameter bit          SEG_ACTIVE_LOW = 1'b0,
    parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic                    lz_blank_i,
    input  logic                    blank_i,
    output logic [15:0]             data_o,
    output logic                    trigger_o,
    output logic [2:0]              digit_idx_o
);

    localparam int unsigned DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [7:0]  SEG_INV = {8{SEG_ACTIVE_LOW}};
    localparam logic [7:0]  DIG_INV = {8{DIG_ACTIVE_LOW}};
    localparam logic [15:0] WORD_OFF = {SEG_INV, DIG_INV};

    // A slot shorter than a full 16-bit shift-out would corrupt the 595 transfer.
    if (SCAN_DIV < 40 || NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_param_check
        $error("display_scan_driver: SCAN_DIV must be >= 40 and NUM_DIGITS in 1..8");
    end

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]       scan_idx_q, scan_idx_d;
    logic [15:0]      data_q, data_d;
    logic [2:0]       digit_idx_q, digit_idx_d;
    logic             load_q, load_d;
    logic             trigger_q, trigger_d;

    logic             load_c;
    logic [3:0]       cur_digit;
    logic             cur_dp;
    logic             upper_zero;
    logic [7:0]       seg_raw;
    logic [7:0]       sel_raw;
    logic [15:0]      word_c;

    function automatic logic [6:0] seg_encode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            4'd15:   s = 7'h40;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Word for the digit currently addressed by scan_idx, polarity applied last.
    always_comb begin
        cur_digit  = 4'h0;
        cur_dp     = 1'b0;
        upper_zero = 1'b1;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (3'(j) == scan_idx_q) begin
                cur_digit = digits_i[4*j +: 4];
                cur_dp    = dp_i[j];
            end
            if (3'(j) >= scan_idx_q && digits_i[4*j +: 4] != 4'h0) begin
                upper_zero = 1'b0;
            end
        end

        seg_raw = {cur_dp, seg_encode(cur_digit)};
        if (lz_blank_i && scan_idx_q != 3'd0 && upper_zero) begin
            seg_raw[6:0] = 7'h00;
        end
        sel_raw = 8'd1 << scan_idx_q;
        if (blank_i) begin
            seg_raw = 8'h00;
            sel_raw = 8'h00;
        end
        word_c = {seg_raw ^ SEG_INV, sel_raw ^ DIG_INV};
    end

    // Slot divider, scan index and load/trigger sequencing.
    always_comb begin
        load_c      = (div_cnt_q == DIV_W'(SCAN_DIV - 1));
        div_cnt_d   = div_cnt_q + DIV_W'(1);
        scan_idx_d  = scan_idx_q;
        data_d      = data_q;
        digit_idx_d = digit_idx_q;
        load_d      = load_c;
        trigger_d   = load_q;
        if (load_c) begin
            div_cnt_d   = '0;
            data_d      = word_c;
            digit_idx_d = scan_idx_q;
            scan_idx_d  = (scan_idx_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : scan_idx_q + 3'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_cnt_q   <= '0;
            scan_idx_q  <= 3'd0;
            data_q      <= WORD_OFF;
            digit_idx_q <= 3'd0;
            load_q      <= 1'b0;
            trigger_q   <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            scan_idx_q  <= scan_idx_d;
            data_q      <= data_d;
            digit_idx_q <= digit_idx_d;
            load_q      <= load_d;
            trigger_q   <= trigger_d;
        end
    end

    assign data_o      = data_q;
    assign trigger_o   = trigger_q;
    assign digit_idx_o = digit_idx_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// Directed bench for display_scan_driver (4 digits, SCAN_DIV = 40, default polarities).
module tb_display_scan_driver;

    localparam int unsigned ND  = 4;
    localparam int unsigned DIV = 40;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   digits;
    logic [ND-1:0] dp;
    logic          lz_blank;
    logic          blank;
    logic [15:0]   data;
    logic          trig;
    logic [2:0]    idx;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_trig = 0;

    display_scan_driver #(
        .NUM_DIGITS(ND), .SCAN_DIV(DIV), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk_i(clk), .rst_i(rst), .digits_i(digits), .dp_i(dp),
        .lz_blank_i(lz_blank), .blank_i(blank),
        .data_o(data), .trigger_o(trig), .digit_idx_o(idx)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for the next trigger and check word, index, spacing and width.
    task automatic next_load(input string tag, input logic [15:0] exp_w, input logic [2:0] exp_i);
        int  n;
        logic found;
        n = 0;
        found = 1'b0;
        while (!found && n < 3 * DIV) begin
            tick();
            n++;
            if (trig === 1'b1) found = 1'b1;
        end
        chk({tag, "_trig_seen"}, 16'(found), 16'd1);
        if (found) begin
            chk({tag, "_spacing"}, 16'(cyc - last_trig), 16'(DIV));
            chk({tag, "_data"}, data, exp_w);
            chk({tag, "_idx"}, 16'(idx), 16'(exp_i));
            last_trig = cyc;
            tick();
            chk({tag, "_trig_width"}, 16'(trig), 16'd0);
        end
    endtask

    initial begin
        int  n;
        logic quiet;

        rst = 1'b1; digits = 16'h1234; dp = '0; lz_blank = 1'b0; blank = 1'b0;
        tick();
        tick();
        chk("rst_data", data, 16'h00FF);
        chk("rst_trig", 16'(trig), 16'd0);
        chk("rst_idx", 16'(idx), 16'd0);

        // First word appears on the 40th edge after release, trigger on the 41st.
        rst = 1'b0;
        quiet = 1'b1;
        for (int i = 1; i < DIV; i++) begin
            tick();
            if (data !== 16'h00FF || trig !== 1'b0) quiet = 1'b0;
        end
        chk("pre_load_quiet", 16'(quiet), 16'd1);
        tick();
        chk("first_data", data, 16'h66FE);
        chk("first_trig_low", 16'(trig), 16'd0);
        chk("first_idx", 16'(idx), 16'd0);
        tick();
        chk("first_trig", 16'(trig), 16'd1);
        last_trig = cyc;
        tick();
        chk("first_trig_width", 16'(trig), 16'd0);

        next_load("scan1", 16'h4FFD, 3'd1);
        next_load("scan2", 16'h5BFB, 3'd2);
        next_load("scan3", 16'h06F7, 3'd3);
        next_load("scan0", 16'h66FE, 3'd0);

        // Mid-slot change: 5 cycles after the load, not visible until the next load.
        tick(); tick(); tick();
        digits = 16'h1284;
        for (int i = 0; i < 10; i++) tick();
        chk("midslot_hold", data, 16'h66FE);
        next_load("midslot_new", 16'h7FFD, 3'd1);

        digits = 16'h0070; lz_blank = 1'b1; dp = 4'b1000;
        next_load("lz_d2", 16'h00FB, 3'd2);
        next_load("lz_d3", 16'h80F7, 3'd3);
        next_load("lz_d0", 16'h3FFE, 3'd0);
        next_load("lz_d1", 16'h07FD, 3'd1);

        digits = 16'hFC00; lz_blank = 1'b0; dp = '0;
        next_load("code_c", 16'h00FB, 3'd2);
        next_load("code_f", 16'h40F7, 3'd3);

        digits = 16'h8888; dp = 4'b1111; blank = 1'b1;
        next_load("blank0", 16'h00FF, 3'd0);
        next_load("blank1", 16'h00FF, 3'd1);

        // Reset asserted on the trigger cycle itself.
        blank = 1'b0; dp = '0; digits = 16'h1234;
        n = 0;
        while (trig !== 1'b1 && n < 3 * DIV) begin
            tick();
            n++;
        end
        chk("pre_rst_trig", 16'(trig), 16'd1);
        rst = 1'b1;
        tick();
        chk("midrst_trig", 16'(trig), 16'd0);
        chk("midrst_data", data, 16'h00FF);
        chk("midrst_idx", 16'(idx), 16'd0);
        rst = 1'b0;
        n = 0;
        quiet = 1'b1;
        while (data === 16'h00FF && n < 2 * DIV) begin
            tick();
            n++;
            if (trig !== 1'b0) quiet = 1'b0;
        end
        chk("midrst_reload_cycles", 16'(n), 16'(DIV));
        chk("midrst_no_stale_trig", 16'(quiet), 16'd1);
        chk("midrst_reload_data", data, 16'h66FE);
        chk("midrst_reload_idx", 16'(idx), 16'd0);
        tick();
        chk("midrst_reload_trig", 16'(trig), 16'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
